hilo_div: RTL and testbench

HILO_DIV -- requirements
Module: hilo_div

---
 rtl/hilo_div.sv | 148 ++++++++++++++
 tb/tb_hilo_div.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div.sv
// Multi-cycle 32-bit restoring divider for the HI/LO unit (DIV/DIVU).
// Produces one quotient bit per clock and issues a single-cycle HI/LO write pulse.
module hilo_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [32:0] r_rem;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [33:0] w_sub;
  logic [32:0] w_keep;
  logic [32:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic        w_fits;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
    logic [31:0] res;
    if (en) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
  always_comb begin
    w_sub    = {1'b0, r_rem, r_quo[31]} - {2'b00, r_div};
    w_keep   = {r_rem[31:0], r_quo[31]};
    w_fits   = ~w_sub[33];
    w_rem_nx = w_keep;
    w_quo_nx = {r_quo[30:0], 1'b0};
    if (w_fits) begin
      w_rem_nx = w_sub[32:0];
      w_quo_nx = {r_quo[30:0], 1'b1};
    end else begin
      w_rem_nx = w_keep;
      w_quo_nx = {r_quo[30:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FREE;
      r_cnt   <= 6'd0;
      r_quo   <= 32'd0;
      r_rem   <= 33'd0;
      r_div   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      hi_o    <= 32'd0;
      lo_o    <= 32'd0;
      whilo_o <= 1'b0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          whilo_o <= 1'b0;
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            // Signed operands are reduced to magnitudes; signs are reapplied at the end.
            r_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r <= signed_div_i & opdata1_i[31];
            r_quo   <= cond_neg(opdata1_i, signed_div_i & opdata1_i[31]);
            r_div   <= cond_neg(opdata2_i, signed_div_i & opdata2_i[31]);
            r_rem   <= 33'd0;
            r_cnt   <= 6'd0;
            busy_o  <= 1'b1;
            r_state <= (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            busy_o  <= 1'b0;
            r_state <= S_FREE;
          end else begin
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
            whilo_o <= 1'b1;
            ready_o <= 1'b1;
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            busy_o  <= 1'b0;
            r_cnt   <= 6'd0;
            r_state <= S_FREE;
          end else begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              lo_o    <= cond_neg(w_quo_nx, r_neg_q);
              hi_o    <= cond_neg(w_rem_nx[31:0], r_neg_r);
              whilo_o <= 1'b1;
              ready_o <= 1'b1;
              r_state <= S_END;
            end
          end
        end
        S_END: begin
          whilo_o <= 1'b0;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
          r_cnt   <= 6'd0;
          r_state <= S_FREE;
        end
        default: begin
          whilo_o <= 1'b0;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
          r_cnt   <= 6'd0;
          r_state <= S_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div.sv
// Self-checking bench for hilo_div: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_hilo_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  hilo_div dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .whilo_o      (whilo_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: plain integer division; C-style truncation for signed mode.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Starts an operation (caller is #1 past an edge, DUT idle) and waits for the pulse.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ghi, output logic [31:0] glo, output int lat,
                        output logic busy_ok, output logic hold_ok, output logic rdy);
    logic [31:0] phi, plo;
    phi = hi_o; plo = lo_o;
    busy_ok = 1'b1; hold_ok = 1'b1; lat = -1; rdy = 1'b0;
    start_i = 1'b1; signed_div_i = sgn; opdata1_i = a; opdata2_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (!busy_o) busy_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (whilo_o) begin
        lat = n;
        rdy = ready_o;
        break;
      end
      if (!busy_o) busy_ok = 1'b0;
      if (hi_o !== phi || lo_o !== plo) hold_ok = 1'b0;
    end
    ghi = hi_o; glo = lo_o;
  endtask

  task automatic apply_and_check(input string nm, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ehi,
                                 input logic [31:0] elo, input int elat);
    logic [31:0] ghi, glo;
    int lat;
    logic busy_ok, hold_ok, rdy;
    run_op(sgn, a, b, ghi, glo, lat, busy_ok, hold_ok, rdy);
    chk({nm, ".lat"}, 32'(lat), 32'(elat));
    chk({nm, ".hi"}, ghi, ehi);
    chk({nm, ".lo"}, glo, elo);
    chk({nm, ".ready"}, {31'd0, rdy}, 32'd1);
    chk({nm, ".busy"}, {31'd0, busy_ok}, 32'd1);
    chk({nm, ".hold"}, {31'd0, hold_ok}, 32'd1);
    @(posedge clk); #1;
    chk({nm, ".pulse_end"}, {30'd0, whilo_o, busy_o}, 32'd0);
  endtask

  task automatic watch_no_pulse(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (whilo_o || ready_o) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [63:0] m;
    logic [31:0] ra, rb, h1, l1, h2, l2;
    logic rs;
    int np, p1, p2, lat;

    vecs[0] = '{"udiv_100_7",     1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         32};
    vecs[1] = '{"sdiv_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  32};
    vecs[2] = '{"udiv_m7_2",      1'b0, 32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC,  32};
    vecs[3] = '{"div_by_zero",    1'b0, 32'h0000_1234,  32'd0,          32'd0,          32'd0,          1};
    vecs[4] = '{"sdiv_min_m1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  32};
    vecs[5] = '{"sdiv_m7_m2",     1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd3,          32};
    vecs[6] = '{"sdiv_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  32};
    vecs[7] = '{"udiv_max_1",     1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  32};
    vecs[8] = '{"sdiv_by_zero",   1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1};
    vecs[9] = '{"udiv_0_5",       1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          32};

    rst = 1'b1; start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd9;
    opdata2_i = 32'd3; annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outs", {hi_o, lo_o} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("reset.flags", {29'd0, whilo_o, ready_o, busy_o}, 32'd0);
    start_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // start together with annul in FREE must not capture
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    chk("free_annul.busy", {31'd0, busy_o}, 32'd0);
    watch_no_pulse("free_annul.no_pulse", 40);

    for (int i = 0; i < 10; i++)
      apply_and_check(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                      vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);

    // annul at the 10th ON edge, then a normal op
    apply_and_check("prior_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 32);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_on.busy", {31'd0, busy_o}, 32'd0);
    chk("annul_on.hi", hi_o, 32'd2);
    chk("annul_on.lo", lo_o, 32'd14);
    watch_no_pulse("annul_on.no_pulse", 40);
    apply_and_check("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 32);

    // annul while in BYZERO
    start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_byzero.busy", {31'd0, busy_o}, 32'd0);
    watch_no_pulse("annul_byzero.no_pulse", 5);
    chk("annul_byzero.lo", lo_o, 32'd3);

    // start_i re-asserted with other operands while busy is ignored
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
    @(posedge clk); #1;
    opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 10) start_i = 1'b0;
      if (whilo_o) begin
        lat = n;
        break;
      end
    end
    chk("busy_ignore.lat", 32'(lat), 32'd32);
    chk("busy_ignore.hi", hi_o, 32'd6);
    chk("busy_ignore.lo", lo_o, 32'd142);
    @(posedge clk); #1;

    // reset at the 20th ON edge discards the op
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd777; opdata2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid.hi", hi_o, 32'd0);
    chk("rst_mid.lo", lo_o, 32'd0);
    chk("rst_mid.flags", {29'd0, whilo_o, ready_o, busy_o}, 32'd0);
    watch_no_pulse("rst_mid.no_pulse", 40);

    // back-to-back: start held high through END
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(posedge clk); #1;
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FFF9; opdata2_i = 32'd2;
    np = 0; p1 = -1; p2 = -1;
    h1 = 32'd0; l1 = 32'd0; h2 = 32'd0; l2 = 32'd0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 34) start_i = 1'b0;
      if (whilo_o) begin
        np++;
        if (np == 1) begin p1 = n; h1 = hi_o; l1 = lo_o; end
        if (np == 2) begin p2 = n; h2 = hi_o; l2 = lo_o; end
      end
    end
    chk("b2b.count", 32'(np), 32'd2);
    chk("b2b.first_at", 32'(p1), 32'd32);
    chk("b2b.first_hi", h1, 32'd2);
    chk("b2b.first_lo", l1, 32'd14);
    chk("b2b.second_at", 32'(p2), 32'd66);
    chk("b2b.second_hi", h2, 32'hFFFF_FFFF);
    chk("b2b.second_lo", l2, 32'hFFFF_FFFD);

    // randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      m = ref_div(rs, ra, rb);
      apply_and_check($sformatf("rand%0d", i), rs, ra, rb, m[63:32], m[31:0],
                      (rb == 32'd0) ? 1 : 32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
